instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-aligned fetches, buffers up to two
// responses tagged with their PC, and flushes stale in-flight fetches on redirect.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 2;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_fetch_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] w_outst_nxt;

    logic [AW-1:0] r_fifo_pc    [2];
    logic [AW-1:0] r_fifo_instr [2];
    logic          r_fifo_rd;
    logic          r_fifo_wr;
    logic [CW-1:0] r_fifo_cnt;

    logic [AW-1:0] r_rq_pc [2];
    logic          r_rq_rd;
    logic          r_rq_wr;

    logic w_req_fire;
    logic w_rsp_acc;
    logic w_push;
    logic w_pop;
    logic w_unused_lsb;

    // Redirect targets are forced word-aligned, so the low bits are dropped.
    assign w_unused_lsb = ^redirect_pc[1:0];

    assign imem_req_valid = (r_state == S_RUN) && !redirect_valid &&
                            (({1'b0, r_outst} + {1'b0, r_fifo_cnt}) < 3'd2);
    assign imem_req_addr  = r_fetch_pc;
    assign instr_valid    = (r_fifo_cnt != 2'd0);
    assign instr          = r_fifo_instr[r_fifo_rd];
    assign instr_pc       = r_fifo_pc[r_fifo_rd];

    assign w_req_fire  = imem_req_valid && imem_req_ready;
    assign w_rsp_acc   = imem_rsp_valid && (r_outst != 2'd0);
    assign w_pop       = instr_valid && instr_ready;
    assign w_push      = w_rsp_acc && (r_state == S_RUN) && !redirect_valid;
    assign w_outst_nxt = CW'(r_outst + {1'b0, w_req_fire} - {1'b0, w_rsp_acc});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Any in-flight fetch at redirect time is stale; drain them in FLUSH.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   if (redirect_valid && (w_outst_nxt != 2'd0)) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_outst_nxt == 2'd0) w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_outst    <= '0;
            r_fifo_rd  <= 1'b0;
            r_fifo_wr  <= 1'b0;
            r_fifo_cnt <= '0;
            r_rq_rd    <= 1'b0;
            r_rq_wr    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
                r_rq_pc[i]      <= '0;
            end
        end else begin
            r_outst <= w_outst_nxt;

            // Request-PC queue tracks every in-flight fetch, stale or not.
            if (w_req_fire) begin
                r_rq_pc[r_rq_wr] <= r_fetch_pc;
                r_rq_wr          <= ~r_rq_wr;
            end
            if (w_rsp_acc) begin
                r_rq_rd <= ~r_rq_rd;
            end

            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[AW-1:2], 2'b00};
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (redirect_valid) begin
                r_fifo_rd  <= 1'b0;
                r_fifo_wr  <= 1'b0;
                r_fifo_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_pc[r_fifo_wr]    <= r_rq_pc[r_rq_rd];
                    r_fifo_instr[r_fifo_wr] <= imem_rsp_data;
                    r_fifo_wr               <= ~r_fifo_wr;
                end
                if (w_pop) begin
                    r_fifo_rd <= ~r_fifo_rd;
                end
                r_fifo_cnt <= CW'(r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop});
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: streaming, backpressure,
// redirect flush, request stall, PC wrap and mid-flight reset.
module tb_instr_fetch;

    localparam logic [31:0] DKEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        b_req_valid;
    logic        b_req_ready;
    logic [31:0] b_req_addr;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_data;
    logic        b_instr_valid;
    logic        b_instr_ready;
    logic [31:0] b_instr;
    logic [31:0] b_instr_pc;

    int n_tests = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    instr_fetch u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (b_req_valid),
        .imem_req_ready (b_req_ready),
        .imem_req_addr  (b_req_addr),
        .imem_rsp_valid (b_rsp_valid),
        .imem_rsp_data  (b_rsp_data),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .instr_valid    (b_instr_valid),
        .instr_ready    (b_instr_ready),
        .instr          (b_instr),
        .instr_pc       (b_instr_pc)
    );

    task automatic idle_inputs();
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        b_req_ready    = 1'b1;
        b_rsp_valid    = 1'b0;
        b_rsp_data     = '0;
        b_instr_ready  = 1'b1;
    endtask

    // Leaves rst low just after the last reset edge; next negedge is the BOOT cycle.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_tests++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
        n_tests++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 00000000", imem_req_addr); end
        n_tests++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 00000000", instr); end
        n_tests++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL rst_instr_pc: got %h want 00000000", instr_pc); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL boot_req_valid: got %b want 0", imem_req_valid); end
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL run_req_valid: got %b want 1", imem_req_valid); end
        n_tests++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL run_first_addr: got %h want 00000000", imem_req_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] hs_addr [$];
        logic [31:0] pop_pc [$];
        logic [31:0] pop_data [$];
        logic [31:0] a;
        logic [31:0] got;
        logic        hs;
        int          first_k;
        first_k = -1;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            hs = imem_req_valid && imem_req_ready;
            a  = imem_req_addr;
            if (hs) hs_addr.push_back(a);
            if (instr_valid) begin
                if (first_k < 0) first_k = k;
                pop_pc.push_back(instr_pc);
                pop_data.push_back(instr);
            end
            @(posedge clk); #1;
            imem_rsp_valid = hs;
            imem_rsp_data  = a ^ DKEY;
        end
        imem_rsp_valid = 1'b0;
        n_tests++; if (first_k != 3) begin n_bad++; $display("FAIL stream_latency: got %0d want 3", first_k); end
        for (int i = 0; i < 3; i++) begin
            got = (i < hs_addr.size()) ? hs_addr[i] : 32'hDEAD_BEEF;
            n_tests++; if (got !== 32'(4 * i)) begin n_bad++; $display("FAIL stream_addr%0d: got %h want %h", i, got, 32'(4 * i)); end
            got = (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF;
            n_tests++; if (got !== 32'(4 * i)) begin n_bad++; $display("FAIL stream_pc%0d: got %h want %h", i, got, 32'(4 * i)); end
            got = (i < pop_data.size()) ? pop_data[i] : 32'hDEAD_BEEF;
            n_tests++; if (got !== (32'(4 * i) ^ DKEY)) begin n_bad++; $display("FAIL stream_data%0d: got %h want %h", i, got, 32'(4 * i) ^ DKEY); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        logic        hs;
        int          n_hs;
        n_hs = 0;
        do_reset();
        instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hs = imem_req_valid && imem_req_ready;
            a  = imem_req_addr;
            if (hs) n_hs++;
            @(posedge clk); #1;
            imem_rsp_valid = hs;
            imem_rsp_data  = a ^ DKEY;
        end
        @(negedge clk);
        n_tests++; if (n_hs != 2) begin n_bad++; $display("FAIL bp_req_count: got %0d want 2", n_hs); end
        n_tests++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
        n_tests++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL bp_instr_valid: got %b want 1", instr_valid); end
        n_tests++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL bp_head_pc: got %h want 00000000", instr_pc); end
        instr_ready = 1'b1;
        @(posedge clk); #1 instr_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL bp_resume_valid: got %b want 1", imem_req_valid); end
        n_tests++; if (imem_req_addr !== 32'h8) begin n_bad++; $display("FAIL bp_resume_addr: got %h want 00000008", imem_req_addr); end
        n_tests++; if (instr_pc !== 32'h4) begin n_bad++; $display("FAIL bp_next_pc: got %h want 00000004", instr_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1003;
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_cycle_valid: got %b want 0", imem_req_valid); end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_BAD0;
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL flush1_req_valid: got %b want 0", imem_req_valid); end
        n_tests++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL flush1_instr_valid: got %b want 0", instr_valid); end
        @(posedge clk); #1;
        imem_rsp_data = 32'h0000_BAD4;
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL flush2_req_valid: got %b want 0", imem_req_valid); end
        n_tests++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL flush2_instr_valid: got %b want 0", instr_valid); end
        @(posedge clk); #1;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL post_flush_valid: got %b want 1", imem_req_valid); end
        n_tests++; if (imem_req_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL post_flush_addr: got %h want 00001000", imem_req_addr); end
        n_tests++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL post_flush_instr_valid: got %b want 0", instr_valid); end
        @(posedge clk); #1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_600D;
        @(posedge clk); #1;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL redir_instr_valid: got %b want 1", instr_valid); end
        n_tests++; if (instr_pc !== 32'h0000_1000) begin n_bad++; $display("FAIL redir_instr_pc: got %h want 00001000", instr_pc); end
        n_tests++; if (instr !== 32'h0000_600D) begin n_bad++; $display("FAIL redir_instr: got %h want 0000600d", instr); end
    endtask

    task automatic test_stall();
        do_reset();
        imem_req_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid%0d: got %b want 1", k, imem_req_valid); end
            n_tests++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL stall_addr%0d: got %h want 00000000", k, imem_req_addr); end
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL stall_release_addr: got %h want 00000004", imem_req_addr); end
    endtask

    task automatic test_wrap();
        logic [31:0] hs_addr [$];
        logic [31:0] a;
        logic [31:0] got;
        logic        hs;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hs = b_req_valid && b_req_ready;
            a  = b_req_addr;
            if (hs) hs_addr.push_back(a);
            @(posedge clk); #1;
            b_rsp_valid = hs;
            b_rsp_data  = a ^ DKEY;
        end
        b_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = (i < hs_addr.size()) ? hs_addr[i] : 32'hDEAD_BEEF;
            n_tests++; if (got !== (32'hFFFF_FFF8 + 32'(4 * i))) begin n_bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, got, 32'hFFFF_FFF8 + 32'(4 * i)); end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        @(posedge clk); #1;
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_0BAD;
        @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_boot_valid: got %b want 0", imem_req_valid); end
        @(posedge clk); #1;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_instr_valid0: got %b want 0", instr_valid); end
        n_tests++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL mid_req_valid: got %b want 1", imem_req_valid); end
        n_tests++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL mid_req_addr: got %h want 00000000", imem_req_addr); end
        @(negedge clk);
        n_tests++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_instr_valid1: got %b want 0", instr_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_stall();
        test_wrap();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", n_tests, n_bad);
        $finish;
    end

endmodule
